// File: rtl/toggle_chk_pkg.sv
// Shared types for the toggle sample checker: FSM states, event kinds and the
// event record carried by the one-entry event register.
package toggle_chk_pkg;

    // Widest timestamp an event record can carry; TS_W of the checker must not exceed it.
    localparam int TS_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2,
        FAIL  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EV_MISMATCH = 2'd0,
        EV_STUCK    = 2'd1,
        EV_DONE     = 2'd2
    } ev_kind_e;

    typedef struct packed {
        ev_kind_e              kind;
        logic [TS_W_MAX-1:0]   stamp;
    } ev_t;

endpackage

// File: rtl/tsc_event_reg.sv
// One-entry valid/ready holding register for checker events. A new event is
// taken when the slot is empty or is being drained in the same cycle;
// otherwise it is dropped and the sticky overflow flag is set.
module tsc_event_reg
    import toggle_chk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  ev_t  push_ev,
    input  logic clr_ovf,
    input  logic ready,
    output logic valid,
    output ev_t  ev,
    output logic ovf
);

    logic valid_reg;
    logic ovf_reg;
    ev_t  ev_reg;

    // Slot load/drain and drop detection; the payload only changes on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            ev_reg    <= '0;
        end else begin
            if (push) begin
                if (!valid_reg || ready) begin
                    valid_reg <= 1'b1;
                    ev_reg    <= push_ev;
                end else begin
                    ovf_reg   <= 1'b1;
                end
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
            if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign valid = valid_reg;
    assign ev    = ev_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/toggle_sample_checker.sv
// Toggle sample checker: registers the observed line, compares each sample of a
// run against an alternating reference, counts matches/mismatches, detects a
// stuck line and reports timestamped events through a valid/ready port.
// Build option: define TOGGLE_SAMPLE_CHECKER_SYNC2_EN to pass `a` through a
// 2-flop synchronizer first (input latency 3; comparisons start 2 cycles later).
module toggle_sample_checker
    import toggle_chk_pkg::*;
#(
    parameter int WINDOW    = 16,
    parameter int STUCK_LIM = 4,
    parameter int CNT_W     = 8,
    parameter int TS_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             start,
    input  logic             expect_init,
    output logic             busy,
    output logic             done,
    output logic             stuck,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_kind,
    output logic [TS_W-1:0]  ev_time,
    output logic             ev_ovf
);

    localparam int SC_W = $clog2(WINDOW + 1);
    localparam int RL_W = $clog2(STUCK_LIM + 1);

`ifdef TOGGLE_SAMPLE_CHECKER_SYNC2_EN
    // Cycles to let the synchronizer fill before the first comparison.
    localparam logic [1:0] WARMUP = 2'd2;
`else
    localparam logic [1:0] WARMUP = 2'd0;
`endif

    logic             a_q;
    logic [TS_W-1:0]  ts_reg;

    state_e           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             stuck_reg;
    logic             exp_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] match_cnt_reg;
    logic [CNT_W-1:0] mismatch_cnt_reg;
    logic [SC_W-1:0]  sample_cnt_reg;
    logic [RL_W-1:0]  run_reg;
    logic [1:0]       warm_reg;

    logic             start_ok;
    logic             compare_en;
    logic             is_match;
    logic [RL_W-1:0]  run_next;
    logic [SC_W-1:0]  sample_cnt_next;
    logic             hit_stuck;
    logic             hit_done;
    logic             push;
    ev_t              push_ev;
    ev_t              ev_q;
    logic             unused_stamp;

`ifdef TOGGLE_SAMPLE_CHECKER_SYNC2_EN
    logic [1:0] sync_reg;

    // Two-flop synchronizer ahead of the sample register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], a};
        end
    end

    // Sample register fed from the synchronizer output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 1'b0;
        end else begin
            a_q <= sync_reg[1];
        end
    end
`else
    // Sample register: one cycle of input latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 1'b0;
        end else begin
            a_q <= a;
        end
    end
`endif

    // Free-running cycle timestamp, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end

    // Per-sample decisions: match, run length, stuck/done detection and event raise.
    always_comb begin
        start_ok        = start && (state_reg != CHECK);
        compare_en      = (state_reg == CHECK) && (warm_reg == 2'd0);
        is_match        = (a_q == exp_reg);
        sample_cnt_next = sample_cnt_reg + SC_W'(1);
        run_next        = RL_W'(1);
        if (sample_cnt_reg != '0 && a_q == prev_reg) begin
            // run_reg never exceeds STUCK_LIM-1 while checking, so this cannot wrap.
            run_next = run_reg + RL_W'(1);
        end
        hit_stuck = (run_next == RL_W'(STUCK_LIM));
        hit_done  = !hit_stuck && (sample_cnt_next == SC_W'(WINDOW));
        push      = compare_en && (hit_stuck || hit_done || !is_match);
        push_ev.kind = EV_MISMATCH;
        if (hit_stuck) begin
            push_ev.kind = EV_STUCK;
        end else if (hit_done) begin
            push_ev.kind = EV_DONE;
        end
        push_ev.stamp = TS_W_MAX'(ts_reg);
    end

    // Run-control FSM with registered status outputs and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            stuck_reg        <= 1'b0;
            exp_reg          <= 1'b0;
            prev_reg         <= 1'b0;
            match_cnt_reg    <= '0;
            mismatch_cnt_reg <= '0;
            sample_cnt_reg   <= '0;
            run_reg          <= '0;
            warm_reg         <= 2'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, FAIL: begin
                    if (start_ok) begin
                        state_reg        <= CHECK;
                        busy_reg         <= 1'b1;
                        stuck_reg        <= 1'b0;
                        exp_reg          <= expect_init;
                        match_cnt_reg    <= '0;
                        mismatch_cnt_reg <= '0;
                        sample_cnt_reg   <= '0;
                        run_reg          <= '0;
                        warm_reg         <= WARMUP;
                    end
                end
                CHECK: begin
                    if (warm_reg != 2'd0) begin
                        warm_reg <= warm_reg - 2'd1;
                    end else begin
                        if (is_match) begin
                            if (match_cnt_reg != '1) begin
                                match_cnt_reg <= match_cnt_reg + CNT_W'(1);
                            end
                        end else if (mismatch_cnt_reg != '1) begin
                            mismatch_cnt_reg <= mismatch_cnt_reg + CNT_W'(1);
                        end
                        exp_reg        <= ~exp_reg;
                        prev_reg       <= a_q;
                        run_reg        <= run_next;
                        sample_cnt_reg <= sample_cnt_next;
                        if (hit_stuck) begin
                            state_reg <= FAIL;
                            busy_reg  <= 1'b0;
                            stuck_reg <= 1'b1;
                        end else if (hit_done) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    tsc_event_reg u_event_reg (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_ev (push_ev),
        .clr_ovf (start_ok),
        .ready   (ev_ready),
        .valid   (ev_valid),
        .ev      (ev_q),
        .ovf     (ev_ovf)
    );

    // Upper stamp bits beyond TS_W are always zero and intentionally dropped.
    assign unused_stamp = ^ev_q.stamp;

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign stuck        = stuck_reg;
    assign match_cnt    = match_cnt_reg;
    assign mismatch_cnt = mismatch_cnt_reg;
    assign ev_kind      = ev_q.kind;
    assign ev_time      = ev_q.stamp[TS_W-1:0];

endmodule

// File: tb/tb_toggle_sample_checker.sv
// Directed bench for toggle_sample_checker: clean run, inverted phase, stuck line,
// backpressure/overflow and asynchronous reset mid-run. Timing expectations
// shift by 2 cycles when built with TOGGLE_SAMPLE_CHECKER_SYNC2_EN.
module tb_toggle_sample_checker;

`ifdef TOGGLE_SAMPLE_CHECKER_SYNC2_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a = 1'b0;
    logic        start = 1'b0;
    logic        expect_init = 1'b0;
    logic        busy;
    logic        done;
    logic        stuck;
    logic [7:0]  match_cnt;
    logic [7:0]  mismatch_cnt;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [1:0]  ev_kind;
    logic [15:0] ev_time;
    logic        ev_ovf;

    int n_checks = 0;
    int n_pass = 0;
    int tb_ts = 0;
    int t0 = 0;
    int hs_cnt = 0;
    int hs_mm = 0;
    int done_cnt = 0;
    int last_kind = 0;
    int last_time = 0;
    int hs_base = 0;
    int mm_base = 0;
    int done_base = 0;

    toggle_sample_checker dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .start        (start),
        .expect_init  (expect_init),
        .busy         (busy),
        .done         (done),
        .stuck        (stuck),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_kind      (ev_kind),
        .ev_time      (ev_time),
        .ev_ovf       (ev_ovf)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: value the DUT timestamp holds before each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= 0;
        else     tb_ts <= tb_ts + 1;
    end

    // Observe handshakes and done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            hs_cnt    <= hs_cnt + 1;
            hs_mm     <= hs_mm + ((ev_kind == 2'd0) ? 1 : 0);
            last_kind <= int'(ev_kind);
            last_time <= int'(ev_time);
            $display("event kind=%0d time=%0d", ev_kind, ev_time);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        hs_base   = hs_cnt;
        mm_base   = hs_mm;
        done_base = done_cnt;
    endtask

    // Pulse start with `a` at a0 during the start cycle; records the start timestamp.
    task automatic do_start(input logic init, input logic a0);
        a           = a0;
        expect_init = init;
        start       = 1'b1;
        t0          = tb_ts;
        tick();
        start       = 1'b0;
    endtask

    task automatic run_toggle(input int n);
        for (int i = 0; i < n; i++) begin
            a = ~a;
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_match", 32'(match_cnt), 0);
        check("rst_mismatch", 32'(mismatch_cnt), 0);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_ovf", 32'(ev_ovf), 0);

        // Clean run: a toggles in phase with the reference.
        mark();
        do_start(1'b0, 1'b0);
        check("clean_busy", 32'(busy), 1);
        run_toggle(16 + L + 3);
        check("clean_match", 32'(match_cnt), 16);
        check("clean_mismatch", 32'(mismatch_cnt), 0);
        check("clean_done_pulses", 32'(done_cnt - done_base), 1);
        check("clean_events", 32'(hs_cnt - hs_base), 1);
        check("clean_kind", 32'(last_kind), 2);
        check("clean_time", 32'(last_time), 32'(t0 + 16 + L));
        check("clean_stuck", 32'(stuck), 0);
        check("clean_busy_end", 32'(busy), 0);

        // Inverted phase: every sample mismatches, the last event is DONE.
        mark();
        do_start(1'b1, 1'b0);
        run_toggle(16 + L + 3);
        check("inv_match", 32'(match_cnt), 0);
        check("inv_mismatch", 32'(mismatch_cnt), 16);
        check("inv_events", 32'(hs_cnt - hs_base), 16);
        check("inv_mm_events", 32'(hs_mm - mm_base), 15);
        check("inv_last_kind", 32'(last_kind), 2);
        check("inv_ovf", 32'(ev_ovf), 0);
        check("inv_done_pulses", 32'(done_cnt - done_base), 1);

        // Stuck line: a held 1 -> STUCK on the 4th sample.
        mark();
        do_start(1'b0, 1'b1);
        repeat (4 + L) tick();
        check("stk_stuck", 32'(stuck), 1);
        check("stk_busy", 32'(busy), 0);
        check("stk_match", 32'(match_cnt), 2);
        check("stk_mismatch", 32'(mismatch_cnt), 2);
        repeat (3) tick();
        check("stk_events", 32'(hs_cnt - hs_base), 3);
        check("stk_kind", 32'(last_kind), 1);
        check("stk_time", 32'(last_time), 32'(t0 + 4 + L));
        check("stk_no_done", 32'(done_cnt - done_base), 0);

        // Restart out of FAIL clears the stuck flag and counters.
        do_start(1'b0, 1'b0);
        check("restart_stuck", 32'(stuck), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_match", 32'(match_cnt), 0);
        run_toggle(16 + L + 3);
        check("restart_match_end", 32'(match_cnt), 16);

        // Backpressure: first MISMATCH held, later events dropped.
        ev_ready = 1'b0;
        mark();
        do_start(1'b1, 1'b0);
        run_toggle(1 + L);
        check("bp_valid", 32'(ev_valid), 1);
        check("bp_kind", 32'(ev_kind), 0);
        check("bp_time", 32'(ev_time), 32'(t0 + 1 + L));
        check("bp_ovf_first", 32'(ev_ovf), 0);
        run_toggle(1);
        check("bp_ovf", 32'(ev_ovf), 1);
        check("bp_time_hold", 32'(ev_time), 32'(t0 + 1 + L));
        run_toggle(16);
        check("bp_valid_end", 32'(ev_valid), 1);
        check("bp_kind_end", 32'(ev_kind), 0);
        check("bp_time_end", 32'(ev_time), 32'(t0 + 1 + L));
        check("bp_no_hs", 32'(hs_cnt - hs_base), 0);
        check("bp_done_pulse", 32'(done_cnt - done_base), 1);
        ev_ready = 1'b1;
        repeat (3) tick();
        check("bp_one_hs", 32'(hs_cnt - hs_base), 1);
        check("bp_hs_kind", 32'(last_kind), 0);
        check("bp_hs_time", 32'(last_time), 32'(t0 + 1 + L));
        check("bp_valid_drained", 32'(ev_valid), 0);

        // Asynchronous reset between edges after sample 5.
        ev_ready = 1'b0;
        do_start(1'b1, 1'b0);
        check("mid_ovf_cleared", 32'(ev_ovf), 0);
        run_toggle(5 + L);
        check("mid_mismatch_pre", 32'(mismatch_cnt), 5);
        check("mid_valid_pre", 32'(ev_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_mismatch", 32'(mismatch_cnt), 0);
        check("mid_valid", 32'(ev_valid), 0);
        check("mid_ovf", 32'(ev_ovf), 0);
        tick();
        rst = 1'b0;
        ev_ready = 1'b1;
        tick();
        check("mid_idle_busy", 32'(busy), 0);
        do_start(1'b0, 1'b0);
        check("mid_restart_busy", 32'(busy), 1);
        run_toggle(16 + L + 3);
        check("mid_restart_match", 32'(match_cnt), 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_sample_checker.md
Name: toggle_sample_checker

Overview:
- Receiving end of the single-bit toggling stimulus line driven on `clk`.
- Registers the line on every posedge, then compares each sample against an internally generated alternating reference.
- Counts matches and mismatches, and detects a stuck line.
- Reports events (mismatch, stuck, done) through a valid/ready port with a timestamp.
- Sits beside the stimulus driver so that bench and hardware checks share one observer.

Parameters:
- WINDOW, 16, number of samples checked per run (≥2).
- STUCK_LIM, 4, consecutive unchanged samples that declare the line stuck (≥2, < WINDOW).
- CNT_W, 8, width of the match/mismatch counters (saturating).
- TS_W, 16, width of the free-running cycle timestamp (wraps).

Ports:
- clk  in  1  system clock, posedge active.
- rst  in  1  asynchronous, active-high reset.
- a  in  1  observed toggling line.
- start  in  1  single-cycle pulse; begins a run when IDLE, DONE or FAIL; ignored in CHECK.
- expect_init  in  1  expected value of the first checked sample.
- busy  out  1  high in CHECK.
- done  out  1  one-cycle pulse on entry to DONE.
- stuck  out  1  level; high in FAIL.
- match_cnt  out  CNT_W  matches in the current or last run.
- mismatch_cnt  out  CNT_W  mismatches in the current or last run.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_kind  out  2  0=MISMATCH, 1=STUCK, 2=DONE.
- ev_time  out  TS_W  timestamp of the sample that caused the event.
- ev_ovf  out  1  sticky; an event was dropped. Cleared by start or rst.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; a_q=0; ts=0; exp=0; sample count=0; run length=0.
- Sampling: a_q <= a at every posedge, so one cycle of input latency. The comparison uses a_q; ts increments every cycle and wraps at 2^TS_W.
- IDLE/DONE/FAIL, on start:
  - exp <= expect_init; counters, ev_ovf and sample count cleared; run length <= 0.
  - Go to CHECK. The first compared sample is a_q in the cycle after start.
- CHECK, each cycle:
  - a_q==exp → match_cnt+1; otherwise mismatch_cnt+1 and raise a MISMATCH event.
  - exp <= ~exp.
  - Run length: +1 if a_q equals its previous sample; reset to 1 if it differs. The first sample of a run sets run length to 1.
  - If run length reaches STUCK_LIM → raise a STUCK event and go to FAIL. STUCK replaces any MISMATCH raised in the same cycle.
  - Else, on the WINDOW-th sample → raise a DONE event, pulse done, go to DONE. DONE replaces any MISMATCH raised in the same cycle.
- Counters saturate at 2^CNT_W−1.
- Event port:
  - One-entry holding register.
  - ev_valid, ev_kind and ev_time stay stable until ev_valid && ev_ready.
  - Event raised while the register is empty → ev_valid rises the next cycle.
  - Event raised while full with no handshake that cycle → the new event is dropped and ev_ovf is set.
  - Handshake in the same cycle as a new event → the new event is loaded and nothing is dropped.
- DONE and FAIL hold their counters until the next start.
- rst in mid-run aborts immediately to the reset values; any pending event is lost.

Optional Feature:
- Macro: TOGGLE_SAMPLE_CHECKER_SYNC2_EN.
- Defined: `a` passes through a 2-flop synchronizer before a_q, so input latency is 3 cycles. The first compared sample is the synchronized value 3 cycles after start.
- Undefined: single register as described above, latency 1.
- Event semantics and timestamps (time of comparison) are identical in both builds.

Decomposition:
- Package toggle_chk_pkg contains:
  - state enum: IDLE, CHECK, DONE, FAIL;
  - ev_kind enum: EV_MISMATCH=0, EV_STUCK=1, EV_DONE=2;
  - a packed event struct {kind, time}.
- One sub-module, tsc_event_reg: the one-entry valid/ready holding register with overflow flag.

Test Plan:
- Clean run: rst pulse; start with expect_init=0; `a` toggles every clk starting 0 on the first checked sample; ev_ready=1 → match_cnt=16, mismatch_cnt=0, done pulse, single DONE event, stuck=0.
- Inverted phase: same stimulus with expect_init=1 → mismatch_cnt=16, 16 MISMATCH events (the last replaced by DONE), match_cnt=0.
- Stuck: `a` held 1 after start → STUCK event on the 4th sample, stuck=1, state FAIL, done never pulses; a new start clears it.
- Backpressure: expect_init=1, ev_ready=0 → first MISMATCH held stable, ev_ovf=1 by the 2nd sample; releasing ev_ready yields exactly one handshake for the held event.
- Async reset mid-run: assert rst at sample 5 between clock edges → busy, counters and ev_valid are 0 immediately; after release the state is IDLE and start is accepted.
- SYNC2 build: define TOGGLE_SAMPLE_CHECKER_SYNC2_EN and use expect_init equal to `a` at start+3 → match_cnt=16, mismatch_cnt=0, and the DONE timestamp equals the undefined-build value plus 2.
